// File: rtl/softmax_prob_unpacker_if.sv
// softmax_prob_unpacker_if: vector-in / beat-out bus of the softmax probability unpacker.
interface softmax_prob_unpacker_if #(
  parameter int N     = 64,
  parameter int LANES = 4
);
  logic               i_en;
  logic [3:0]         i_length_mode;
  logic               i_valid;
  logic [N*16-1:0]    i_prob_flat;
  logic               i_ready;
  logic               o_valid;
  logic [LANES*16-1:0] o_data;
  logic [LANES-1:0]   o_keep;
  logic               o_last;
  logic               o_overflow;
  modport master (
    output i_en, i_length_mode, i_valid, i_prob_flat, i_ready,
    input  o_valid, o_data, o_keep, o_last, o_overflow
  );
  modport slave (
    input  i_en, i_length_mode, i_valid, i_prob_flat, i_ready,
    output o_valid, o_data, o_keep, o_last, o_overflow
  );
endinterface

// File: rtl/softmax_prob_unpacker.sv
// softmax_prob_unpacker: ping-pong capture of N-wide probability vectors, streamed LANES per beat.
module softmax_prob_unpacker #(
  parameter int N     = 64,
  parameter int LANES = 4
) (
  input logic                     i_clk,
  input logic                     i_rst,
  softmax_prob_unpacker_if.slave  bus
);
  localparam int AW = $clog2(N);
  localparam int LW = AW + 1;
  typedef enum logic {IDLE, STREAM} state_t;
  state_t          state_q, state_d;
  logic [15:0]     buf_q [2][N];
  logic [LW-1:0]   len_q [2];
  logic [LW-1:0]   len_in;
  logic [1:0]      full_q, full_d;
  logic            rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   beat_q, beat_d;
  logic            ovf_q, ovf_d;
  logic            acc, last, last_acc, cap_ok, cap;
  always_comb begin
    len_in   = int'(bus.i_length_mode) >= AW ? LW'(N) : LW'(1) << bus.i_length_mode;
    last     = int'(beat_q) * LANES + LANES >= int'(len_q[rd_ptr_q]);
    acc      = state_q == STREAM && bus.i_ready;
    last_acc = acc && last;
    // the buffer being freed this cycle may take the incoming vector
    cap_ok   = !full_q[wr_ptr_q] || (last_acc && rd_ptr_q == wr_ptr_q);
    cap      = bus.i_valid && cap_ok;
    ovf_d    = bus.i_valid && !cap_ok;
    full_d   = full_q;
    if (last_acc) full_d[rd_ptr_q] = 1'b0;
    if (cap) full_d[wr_ptr_q] = 1'b1;
    wr_ptr_d = cap ? ~wr_ptr_q : wr_ptr_q;
    rd_ptr_d = last_acc ? ~rd_ptr_q : rd_ptr_q;
    beat_d   = last_acc ? '0 : acc ? beat_q + 1'b1 : beat_q;
    state_d  = state_q == IDLE ? (full_q[rd_ptr_q] ? STREAM : IDLE)
             : last_acc ? (full_q[~rd_ptr_q] ? STREAM : IDLE) : STREAM;
  end
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_q  <= IDLE;
      full_q   <= '0;
      rd_ptr_q <= 1'b0;
      wr_ptr_q <= 1'b0;
      beat_q   <= '0;
      ovf_q    <= 1'b0;
    end else if (bus.i_en) begin
      state_q  <= state_d;
      full_q   <= full_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      beat_q   <= beat_d;
      ovf_q    <= ovf_d;
    end
  end
  always_ff @(posedge i_clk) begin
    if (i_rst && bus.i_en && cap) begin
      len_q[wr_ptr_q] <= len_in;
      for (int k = 0; k < N; k++) buf_q[wr_ptr_q][k] <= bus.i_prob_flat[k*16 +: 16];
    end
  end
  assign bus.o_valid    = state_q == STREAM;
  assign bus.o_last     = bus.o_valid && last;
  assign bus.o_overflow = ovf_q;
  always_comb begin
    for (int j = 0; j < LANES; j++) begin
      bus.o_keep[j]         = bus.o_valid && int'(beat_q) * LANES + j < int'(len_q[rd_ptr_q]);
      bus.o_data[j*16 +: 16] = bus.o_keep[j] ? buf_q[rd_ptr_q][AW'(int'(beat_q) * LANES + j)] : 16'h0;
    end
  end
endmodule

// File: tb/tb_softmax_prob_unpacker.sv
// tb_softmax_prob_unpacker: directed checks on N=8 instances with LANES=2 (a) and LANES=3 (b).
module tb_softmax_prob_unpacker;
  logic clk, rst, en, valid, ready;
  logic [3:0] mode;
  logic [127:0] prob;
  int pass_cnt, total_cnt;
  softmax_prob_unpacker_if #(.N(8), .LANES(2)) a ();
  softmax_prob_unpacker_if #(.N(8), .LANES(3)) b ();
  assign a.i_en = en;
  assign a.i_length_mode = mode;
  assign a.i_valid = valid;
  assign a.i_prob_flat = prob;
  assign a.i_ready = ready;
  assign b.i_en = en;
  assign b.i_length_mode = mode;
  assign b.i_valid = valid;
  assign b.i_prob_flat = prob;
  assign b.i_ready = ready;
  softmax_prob_unpacker #(.N(8), .LANES(2)) u_a (.i_clk(clk), .i_rst(rst), .bus(a));
  softmax_prob_unpacker #(.N(8), .LANES(3)) u_b (.i_clk(clk), .i_rst(rst), .bus(b));
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [127:0] vec(input logic [15:0] base);
    logic [127:0] v;
    for (int k = 0; k < 8; k++) v[k*16 +: 16] = base + 16'(k);
    return v;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [15:0] base, input logic [3:0] m);
    valid = 1'b1;
    prob = vec(base);
    mode = m;
  endtask

  task automatic test_reset;
    rst = 1'b0; en = 1'b1; ready = 1'b1; valid = 1'b0; mode = 4'd3; prob = '0;
    tick; tick;
    total_cnt++; if (a.o_valid !== 1'b0) $display("FAIL reset_valid: got %b exp 0", a.o_valid); else pass_cnt++;
    total_cnt++; if (a.o_data !== 32'h0) $display("FAIL reset_data: got %h exp 0", a.o_data); else pass_cnt++;
    total_cnt++; if (a.o_keep !== 2'b00) $display("FAIL reset_keep: got %b exp 00", a.o_keep); else pass_cnt++;
    total_cnt++; if (a.o_last !== 1'b0) $display("FAIL reset_last: got %b exp 0", a.o_last); else pass_cnt++;
    total_cnt++; if (a.o_overflow !== 1'b0) $display("FAIL reset_ovf: got %b exp 0", a.o_overflow); else pass_cnt++;
    rst = 1'b1;
    tick;
  endtask

  task automatic test_basic;
    logic [47:0] e3 [3];
    logic [31:0] e2;
    e3 = '{48'h0003_0002_0001, 48'h0006_0005_0004, 48'h0000_0008_0007};
    push(16'h1, 4'd3);
    tick;
    valid = 1'b0;
    total_cnt++; if (a.o_valid !== 1'b0) $display("FAIL latency_a: got %b exp 0", a.o_valid); else pass_cnt++;
    total_cnt++; if (b.o_valid !== 1'b0) $display("FAIL latency_b: got %b exp 0", b.o_valid); else pass_cnt++;
    tick;
    for (int i = 0; i < 4; i++) begin
      e2 = {16'(2*i+2), 16'(2*i+1)};
      total_cnt++; if (a.o_valid !== 1'b1) $display("FAIL basic_valid[%0d]: got %b exp 1", i, a.o_valid); else pass_cnt++;
      total_cnt++; if (a.o_data !== e2) $display("FAIL basic_data[%0d]: got %h exp %h", i, a.o_data, e2); else pass_cnt++;
      total_cnt++; if (a.o_keep !== 2'b11) $display("FAIL basic_keep[%0d]: got %b exp 11", i, a.o_keep); else pass_cnt++;
      total_cnt++; if (a.o_last !== (i == 3)) $display("FAIL basic_last[%0d]: got %b exp %b", i, a.o_last, i == 3); else pass_cnt++;
      if (i < 3) begin
        total_cnt++; if (b.o_data !== e3[i]) $display("FAIL l3_data[%0d]: got %h exp %h", i, b.o_data, e3[i]); else pass_cnt++;
        total_cnt++; if (b.o_keep !== (i == 2 ? 3'b011 : 3'b111)) $display("FAIL l3_keep[%0d]: got %b", i, b.o_keep); else pass_cnt++;
        total_cnt++; if (b.o_last !== (i == 2)) $display("FAIL l3_last[%0d]: got %b exp %b", i, b.o_last, i == 2); else pass_cnt++;
      end
      tick;
    end
    total_cnt++; if (a.o_valid !== 1'b0) $display("FAIL basic_idle: got %b exp 0", a.o_valid); else pass_cnt++;
  endtask

  task automatic test_length_modes;
    logic [47:0] e3;
    push(16'h1, 4'd0);
    tick;
    valid = 1'b0;
    tick;
    total_cnt++; if (b.o_data !== 48'h1) $display("FAIL m0_data_b: got %h exp 1", b.o_data); else pass_cnt++;
    total_cnt++; if (b.o_keep !== 3'b001) $display("FAIL m0_keep_b: got %b exp 001", b.o_keep); else pass_cnt++;
    total_cnt++; if (b.o_last !== 1'b1) $display("FAIL m0_last_b: got %b exp 1", b.o_last); else pass_cnt++;
    total_cnt++; if (a.o_data !== 32'h1) $display("FAIL m0_data_a: got %h exp 1", a.o_data); else pass_cnt++;
    total_cnt++; if (a.o_keep !== 2'b01) $display("FAIL m0_keep_a: got %b exp 01", a.o_keep); else pass_cnt++;
    tick;
    total_cnt++; if (b.o_valid !== 1'b0) $display("FAIL m0_idle_b: got %b exp 0", b.o_valid); else pass_cnt++;
    push(16'h20, 4'd7);
    tick;
    valid = 1'b0;
    tick;
    for (int i = 0; i < 4; i++) begin
      total_cnt++; if (a.o_data !== {16'h20 + 16'(2*i+1), 16'h20 + 16'(2*i)}) $display("FAIL m7_data_a[%0d]: got %h", i, a.o_data); else pass_cnt++;
      total_cnt++; if (a.o_last !== (i == 3)) $display("FAIL m7_last_a[%0d]: got %b exp %b", i, a.o_last, i == 3); else pass_cnt++;
      if (i < 3) begin
        e3 = '0;
        for (int j = 0; j < 3; j++) if (3*i+j < 8) e3[j*16 +: 16] = 16'h20 + 16'(3*i+j);
        total_cnt++; if (b.o_data !== e3) $display("FAIL m7_data_b[%0d]: got %h exp %h", i, b.o_data, e3); else pass_cnt++;
        total_cnt++; if (b.o_last !== (i == 2)) $display("FAIL m7_last_b[%0d]: got %b exp %b", i, b.o_last, i == 2); else pass_cnt++;
      end else begin
        total_cnt++; if (b.o_valid !== 1'b0) $display("FAIL m7_idle_b: got %b exp 0", b.o_valid); else pass_cnt++;
      end
      tick;
    end
  endtask

  task automatic test_backpressure;
    logic [15:0] base;
    int bb;
    ready = 1'b0;
    push(16'h100, 4'd3);
    tick;
    push(16'h200, 4'd3);
    tick;
    valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      total_cnt++; if (a.o_valid !== 1'b1 || a.o_data !== 32'h0101_0100 || a.o_last !== 1'b0)
        $display("FAIL bp_hold[%0d]: got v=%b d=%h l=%b exp v=1 d=01010100 l=0", i, a.o_valid, a.o_data, a.o_last); else pass_cnt++;
      tick;
    end
    push(16'h300, 4'd3);
    tick;
    valid = 1'b0;
    total_cnt++; if (a.o_overflow !== 1'b1) $display("FAIL bp_ovf: got %b exp 1", a.o_overflow); else pass_cnt++;
    total_cnt++; if (a.o_data !== 32'h0101_0100) $display("FAIL bp_ovf_data: got %h exp 01010100", a.o_data); else pass_cnt++;
    tick;
    total_cnt++; if (a.o_overflow !== 1'b0) $display("FAIL bp_ovf_pulse: got %b exp 0", a.o_overflow); else pass_cnt++;
    ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      base = i < 4 ? 16'h100 : 16'h200;
      bb = i % 4;
      total_cnt++; if (a.o_valid !== 1'b1 || a.o_data !== {base + 16'(2*bb+1), base + 16'(2*bb)})
        $display("FAIL bp_stream[%0d]: got v=%b d=%h", i, a.o_valid, a.o_data); else pass_cnt++;
      total_cnt++; if (a.o_last !== (bb == 3)) $display("FAIL bp_last[%0d]: got %b exp %b", i, a.o_last, bb == 3); else pass_cnt++;
      tick;
    end
    total_cnt++; if (a.o_valid !== 1'b0) $display("FAIL bp_no_c: got %b exp 0", a.o_valid); else pass_cnt++;
  endtask

  task automatic test_simultaneous;
    logic [15:0] base;
    int bb;
    ready = 1'b0;
    push(16'h400, 4'd3);
    tick;
    push(16'h500, 4'd3);
    tick;
    valid = 1'b0;
    ready = 1'b1;
    tick; tick; tick;
    total_cnt++; if (a.o_last !== 1'b1 || a.o_data !== 32'h0407_0406) $display("FAIL sim_lastbeat: got l=%b d=%h exp l=1 d=04070406", a.o_last, a.o_data); else pass_cnt++;
    push(16'h600, 4'd3);
    tick;
    valid = 1'b0;
    total_cnt++; if (a.o_overflow !== 1'b0) $display("FAIL sim_ovf: got %b exp 0", a.o_overflow); else pass_cnt++;
    for (int i = 0; i < 8; i++) begin
      base = i < 4 ? 16'h500 : 16'h600;
      bb = i % 4;
      total_cnt++; if (a.o_valid !== 1'b1 || a.o_data !== {base + 16'(2*bb+1), base + 16'(2*bb)})
        $display("FAIL sim_stream[%0d]: got v=%b d=%h", i, a.o_valid, a.o_data); else pass_cnt++;
      tick;
    end
    total_cnt++; if (a.o_valid !== 1'b0) $display("FAIL sim_idle: got %b exp 0", a.o_valid); else pass_cnt++;
  endtask

  task automatic test_back_to_back;
    logic [15:0] base;
    int bb;
    ready = 1'b1;
    push(16'h700, 4'd3);
    tick;
    push(16'h800, 4'd3);
    tick;
    valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      base = i < 4 ? 16'h700 : 16'h800;
      bb = i % 4;
      total_cnt++; if (a.o_valid !== 1'b1) $display("FAIL b2b_bubble[%0d]: got %b exp 1", i, a.o_valid); else pass_cnt++;
      total_cnt++; if (a.o_data !== {base + 16'(2*bb+1), base + 16'(2*bb)}) $display("FAIL b2b_data[%0d]: got %h", i, a.o_data); else pass_cnt++;
      total_cnt++; if (a.o_last !== (bb == 3)) $display("FAIL b2b_last[%0d]: got %b exp %b", i, a.o_last, bb == 3); else pass_cnt++;
      tick;
    end
    total_cnt++; if (a.o_valid !== 1'b0) $display("FAIL b2b_idle: got %b exp 0", a.o_valid); else pass_cnt++;
  endtask

  task automatic test_reset_mid;
    ready = 1'b1;
    push(16'h900, 4'd3);
    tick;
    valid = 1'b0;
    tick; tick; tick;
    total_cnt++; if (a.o_data !== 32'h0905_0904) $display("FAIL rm_pre: got %h exp 09050904", a.o_data); else pass_cnt++;
    rst = 1'b0;
    tick;
    total_cnt++; if (a.o_valid !== 1'b0) $display("FAIL rm_valid: got %b exp 0", a.o_valid); else pass_cnt++;
    total_cnt++; if (a.o_overflow !== 1'b0) $display("FAIL rm_ovf: got %b exp 0", a.o_overflow); else pass_cnt++;
    rst = 1'b1;
    push(16'ha00, 4'd3);
    tick;
    valid = 1'b0;
    tick;
    for (int i = 0; i < 4; i++) begin
      total_cnt++; if (a.o_valid !== 1'b1 || a.o_data !== {16'ha00 + 16'(2*i+1), 16'ha00 + 16'(2*i)})
        $display("FAIL rm_stream[%0d]: got v=%b d=%h", i, a.o_valid, a.o_data); else pass_cnt++;
      tick;
    end
    total_cnt++; if (a.o_valid !== 1'b0) $display("FAIL rm_idle: got %b exp 0", a.o_valid); else pass_cnt++;
  endtask

  task automatic test_enable;
    ready = 1'b1;
    push(16'hb00, 4'd3);
    tick;
    valid = 1'b0;
    tick; tick;
    en = 1'b0;
    push(16'hc00, 4'd3);
    for (int i = 0; i < 3; i++) begin
      tick;
      valid = 1'b0;
      total_cnt++; if (a.o_valid !== 1'b1 || a.o_data !== 32'h0b03_0b02 || a.o_overflow !== 1'b0)
        $display("FAIL en_freeze[%0d]: got v=%b d=%h o=%b exp v=1 d=0b030b02 o=0", i, a.o_valid, a.o_data, a.o_overflow); else pass_cnt++;
    end
    en = 1'b1;
    for (int i = 1; i < 4; i++) begin
      total_cnt++; if (a.o_data !== {16'hb00 + 16'(2*i+1), 16'hb00 + 16'(2*i)}) $display("FAIL en_resume[%0d]: got %h", i, a.o_data); else pass_cnt++;
      total_cnt++; if (a.o_last !== (i == 3)) $display("FAIL en_last[%0d]: got %b exp %b", i, a.o_last, i == 3); else pass_cnt++;
      tick;
    end
    total_cnt++; if (a.o_valid !== 1'b0) $display("FAIL en_ignored: got %b exp 0", a.o_valid); else pass_cnt++;
  endtask

  initial begin
    pass_cnt = 0;
    total_cnt = 0;
    test_reset;
    test_basic;
    test_length_modes;
    test_backpressure;
    test_simultaneous;
    test_back_to_back;
    test_reset_mid;
    test_enable;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
